rs_gf_cells: RTL and testbench



---
 rtl/rs_pkg.sv | 17 +
 rtl/rs_gf_cells_if.sv | 22 ++
 rtl/gf2m8_multi.sv | 30 +++
 rtl/icg.sv | 22 ++
 rtl/rs_gf_cells.sv | 22 ++
 tb/tb_rs_gf_cells.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/rs_pkg.sv
// Shared field definitions for the Reed-Solomon datapath.
// GF(2^8) on p(a) = a^8+a^4+a^3+a^2+1.
package rs_pkg;

  localparam int GF_M = 8;

  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef logic [GF_M-1:0] gf8_t;

  // a^8..a^14 reduced mod p(a); entry j is a^(8+j)
  localparam logic [6:0][7:0] GF_RED = {
    8'h13, 8'h87, 8'hCD, 8'hE8,
    8'h74, 8'h3A, GF_POLY[7:0]
  };

endpackage

// File: rtl/rs_gf_cells_if.sv
// Bundle of leaf-cell signals: multiplier operands
// and result, clock-gate enable and gated clock.
interface rs_gf_cells_if;
  import rs_pkg::*;

  gf8_t x;
  gf8_t y;
  gf8_t z;
  logic ena;
  logic gclk;

  modport master (
    output x, y, ena,
    input  z, gclk
  );

  modport slave (
    input  x, y, ena,
    output z, gclk
  );

endinterface

// File: rtl/gf2m8_multi.sv
// Combinational GF(2^8) multiplier, polynomial basis.
// Carry-less product folded with a^8..a^14.
module gf2m8_multi
  import rs_pkg::*;
(
  input  gf8_t x,
  input  gf8_t y,
  output gf8_t z
);

  logic [14:0] pp;
  gf8_t        r;

  // 15-bit carry-less product, then fold bits 14..8
  always_comb begin
    pp = '0;
    for (int i = 0; i < GF_M; i++) begin
      if (y[i[2:0]])
        pp = pp ^ ({7'b0, x} << i[2:0]);
    end
    r = pp[7:0];
    for (int j = 0; j < 7; j++) begin
      if (pp[4'(j + 8)])
        r = r ^ GF_RED[j[2:0]];
    end
  end

  assign z = r;

endmodule

// File: rtl/icg.sv
// Latch-based integrated clock gate.
// Enable latch can be swapped for a library ICG cell.
module icg (
  input  logic clk,
  input  logic rstn,
  input  logic ena,
  output logic gclk
);

  logic en_l;

  // transparent while clk low; reset clears it at once
  always_latch begin
    if (!rstn)
      en_l <= 1'b0;
    else if (!clk)
      en_l <= ena;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/rs_gf_cells.sv
// Leaf-cell wrapper: field multiplier and clock gate
// side by side, no shared state.
module rs_gf_cells (
  input  logic clk,
  input  logic rstn,
  rs_gf_cells_if.slave bus
);

  gf2m8_multi u_mul (
    .x (bus.x),
    .y (bus.y),
    .z (bus.z)
  );

  icg u_icg (
    .clk  (clk),
    .rstn (rstn),
    .ena  (bus.ena),
    .gclk (bus.gclk)
  );

endmodule

// File: tb/tb_rs_gf_cells.sv
// Scoreboard bench for rs_gf_cells: GF multiplier
// against a shift-and-XOR model, ICG pulse shapes.
module tb_rs_gf_cells;
  import rs_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  rs_gf_cells_if bus ();

  rs_gf_cells dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    gf8_t x;
    gf8_t y;
    gf8_t z;
    int   kind;
  } mul_t;

  typedef struct {
    logic a;
    logic b;
    int   cnt;
  } icg_t;

  mul_t mq[$];
  icg_t iq[$];
  event smp;
  string kn[4] = '{"dir", "exh", "comm", "pow"};

  int gcnt;
  int cnt;

  // counter in the gated domain, own async reset
  always_ff @(posedge bus.gclk or negedge rstn)
    if (!rstn) gcnt <= 0;
    else       gcnt <= gcnt + 1;

  function automatic gf8_t ref_mul(gf8_t a, gf8_t b);
    logic [8:0] aa;
    gf8_t bb;
    gf8_t r;
    aa = {1'b0, a};
    bb = b;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa[7:0];
      bb = bb >> 1;
      aa = aa << 1;
      if (aa[8]) aa = aa ^ GF_POLY;
    end
    return r;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic put(gf8_t a, gf8_t b, gf8_t e, int k);
    bus.x = a;
    bus.y = b;
    mq.push_back('{a, b, e, k});
    #1;
    ->smp;
    #1;
  endtask

  task automatic cyc(logic en);
    @(negedge clk);
    #1;
    bus.ena = en;
    if (!rstn) cnt = 0;
    else if (en) cnt++;
    iq.push_back('{en & rstn, en & rstn, cnt});
  endtask

  task automatic glitch(logic first, logic last);
    @(negedge clk);
    #1;
    bus.ena = first;
    if (first) cnt++;
    iq.push_back('{first, first, cnt});
    @(posedge clk);
    #1 bus.ena = ~first;
    #1 bus.ena = first;
    #2 bus.ena = ~first;
    #2 bus.ena = first;
    #1 bus.ena = last;
  endtask

  task automatic rst_mid();
    @(negedge clk);
    #1;
    bus.ena = 1'b1;
    cnt = 0;
    iq.push_back('{1'b1, 1'b0, 0});
    @(posedge clk);
    #5 rstn = 1'b0;
  endtask

  task automatic rel_mid();
    @(negedge clk);
    #1;
    bus.ena = 1'b1;
    iq.push_back('{1'b0, 1'b0, 0});
    @(posedge clk);
    #5 rstn = 1'b1;
  endtask

  // multiplier monitor
  initial begin
    mul_t m;
    forever begin
      @(smp);
      n_chk++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL mul_sb: result with empty queue");
      end else begin
        m = mq.pop_front();
        if (bus.z !== m.z) begin
          n_fail++;
          $display("FAIL mul_%s x=%h y=%h got=%h exp=%h",
                   kn[m.kind], m.x, m.y, bus.z, m.z);
        end
      end
    end
  end

  // clock-gate monitor: two high-phase samples,
  // one low-phase sample plus gated counter
  initial begin
    icg_t e;
    forever begin
      @(posedge clk);
      if (iq.size() > 0) begin
        e = iq[0];
        #3 chk("gclk_hi_early", int'(bus.gclk), int'(e.a));
        #5 chk("gclk_hi_late", int'(bus.gclk), int'(e.b));
        @(negedge clk);
        #5;
        chk("gclk_lo", int'(bus.gclk), 0);
        chk("gcnt", gcnt, e.cnt);
        void'(iq.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    gf8_t p;
    gf8_t e;
    gf8_t a;
    gf8_t b;
    bus.x = '0;
    bus.y = '0;
    bus.ena = 1'b0;
    cnt = 0;

    put(8'h02, 8'h80, 8'h1D, 0);
    put(8'h80, 8'h80, 8'h13, 0);
    put(8'h02, 8'h8E, 8'h01, 0);
    put(8'h5A, 8'h01, 8'h5A, 0);
    put(8'hFF, 8'h00, 8'h00, 0);

    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++) begin
        a = 8'(i);
        b = 8'(j);
        put(a, b, ref_mul(a, b), 1);
      end

    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      put(b, a, ref_mul(a, b), 2);
    end

    p = 8'h01;
    for (int k = 1; k <= 255; k++) begin
      e = (k == 255) ? 8'h01 : ref_mul(p, 8'h02);
      put(p, 8'h02, e, 3);
      p = ref_mul(p, 8'h02);
    end

    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;

    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);

    repeat (4) cyc(1'b1);
    repeat (3) cyc(1'b0);

    glitch(1'b1, 1'b0);
    cyc(1'b0);
    glitch(1'b0, 1'b1);
    cyc(1'b1);
    cyc(1'b0);

    rst_mid();
    cyc(1'b1);
    cyc(1'b1);
    rel_mid();
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);

    repeat (20) cyc(1'($urandom_range(0, 1)));

    for (int i = 0; i < 10; i++) begin
      if (iq.size() == 0) break;
      @(negedge clk);
      #6;
    end
    chk("icg_drain", iq.size(), 0);
    chk("mul_drain", mq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
